// File: rtl/dco_tune_dsm_if.sv
// Frequency-word handshake between the PID loop filter (master) and the DCO tuner (slave).
interface dco_tune_dsm_if #(
    parameter int INT_W  = 5,
    parameter int FRAC_W = 5
);
    logic              fcw_valid;
    logic              fcw_ready;
    logic [INT_W-1:0]  int_word;
    logic [FRAC_W-1:0] frac_word;

    modport master (
        output fcw_valid,
        output int_word,
        output frac_word,
        input  fcw_ready
    );

    modport slave (
        input  fcw_valid,
        input  int_word,
        input  frac_word,
        output fcw_ready
    );
endinterface

// File: rtl/dco_tune_dsm.sv
// DCO tuning back end: shadow/active word registers, first-order sigma-delta dither
// of the fractional word, saturating thermometer bank code and rail detection.
module dco_tune_dsm #(
    parameter int INT_W      = 5,
    parameter int FRAC_W     = 5,
    parameter int MID_CODE   = 16,
    parameter int RAIL_TICKS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 dsm_en,
    dco_tune_dsm_if.slave        fcw,
    output logic [INT_W-1:0]     tune_code,
    output logic [2**INT_W-1:0]  therm_en,
    output logic                 dither_bit,
    output logic                 rail_hi,
    output logic                 rail_lo
);

    localparam int                 NCELL     = 2**INT_W;
    localparam int                 CNT_W     = $clog2(RAIL_TICKS + 1);
    localparam logic [INT_W-1:0]   MAX_CODE  = '1;
    localparam logic [INT_W-1:0]   MID_RST   = INT_W'(MID_CODE);
    localparam logic [CNT_W-1:0]   RAIL_MAX  = CNT_W'(RAIL_TICKS);
    localparam logic [NCELL-1:0]   ALL_ONES  = '1;
    localparam logic [NCELL-1:0]   THERM_RST = ~(ALL_ONES << MID_CODE);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t             state_q, state_d;
    logic               fcw_ready_q, fcw_ready_d;
    logic [INT_W-1:0]   shadow_int_q, shadow_int_d;
    logic [FRAC_W-1:0]  shadow_frac_q, shadow_frac_d;
    logic [INT_W-1:0]   active_int_q, active_int_d;
    logic [FRAC_W-1:0]  active_frac_q, active_frac_d;
    logic [FRAC_W-1:0]  acc_q, acc_d;
    logic [INT_W-1:0]   tune_code_q, tune_code_d;
    logic [NCELL-1:0]   therm_en_q, therm_en_d;
    logic               dither_bit_q, dither_bit_d;
    logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]   lo_cnt_q, lo_cnt_d;
    logic               rail_hi_q, rail_hi_d;
    logic               rail_lo_q, rail_lo_d;

    logic               accept;
    logic               xfer;
    logic               carry;
    logic [INT_W-1:0]   eff_int;
    logic [FRAC_W-1:0]  eff_frac;
    logic [FRAC_W:0]    acc_sum;
    logic [INT_W:0]     code_sum;
    logic [INT_W-1:0]   sat_code;

    always_comb begin
        state_d       = state_q;
        shadow_int_d  = shadow_int_q;
        shadow_frac_d = shadow_frac_q;
        active_int_d  = active_int_q;
        active_frac_d = active_frac_q;
        acc_d         = acc_q;
        tune_code_d   = tune_code_q;
        therm_en_d    = therm_en_q;
        dither_bit_d  = dither_bit_q;
        hi_cnt_d      = hi_cnt_q;
        lo_cnt_d      = lo_cnt_q;
        carry         = 1'b0;
        code_sum      = '0;
        sat_code      = '0;

        accept   = fcw.fcw_valid & fcw_ready_q;
        xfer     = tick & (state_q == PENDING);
        // A transferring tick already computes with the freshly applied word.
        eff_int  = xfer ? shadow_int_q  : active_int_q;
        eff_frac = xfer ? shadow_frac_q : active_frac_q;
        acc_sum  = {1'b0, acc_q} + {1'b0, eff_frac};

        if (accept) begin
            shadow_int_d  = fcw.int_word;
            shadow_frac_d = fcw.frac_word;
            state_d       = PENDING;
        end

        if (tick) begin
            if (xfer) begin
                active_int_d  = shadow_int_q;
                active_frac_d = shadow_frac_q;
                state_d       = IDLE;
            end
            if (dsm_en) begin
                carry = acc_sum[FRAC_W];
                acc_d = acc_sum[FRAC_W-1:0];
            end
            code_sum     = {1'b0, eff_int} + {{INT_W{1'b0}}, carry};
            sat_code     = code_sum[INT_W] ? MAX_CODE : code_sum[INT_W-1:0];
            tune_code_d  = sat_code;
            therm_en_d   = ~(ALL_ONES << sat_code);
            dither_bit_d = carry;

            if (sat_code == MAX_CODE) begin
                hi_cnt_d = (hi_cnt_q == RAIL_MAX) ? hi_cnt_q : hi_cnt_q + CNT_W'(1);
                lo_cnt_d = '0;
            end else if (sat_code == '0) begin
                lo_cnt_d = (lo_cnt_q == RAIL_MAX) ? lo_cnt_q : lo_cnt_q + CNT_W'(1);
                hi_cnt_d = '0;
            end else begin
                hi_cnt_d = '0;
                lo_cnt_d = '0;
            end
        end

        fcw_ready_d = (state_d == IDLE);
        rail_hi_d   = (hi_cnt_d == RAIL_MAX);
        rail_lo_d   = (lo_cnt_d == RAIL_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            fcw_ready_q   <= 1'b1;
            shadow_int_q  <= '0;
            shadow_frac_q <= '0;
            active_int_q  <= MID_RST;
            active_frac_q <= '0;
            acc_q         <= '0;
            tune_code_q   <= MID_RST;
            therm_en_q    <= THERM_RST;
            dither_bit_q  <= 1'b0;
            hi_cnt_q      <= '0;
            lo_cnt_q      <= '0;
            rail_hi_q     <= 1'b0;
            rail_lo_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            fcw_ready_q   <= fcw_ready_d;
            shadow_int_q  <= shadow_int_d;
            shadow_frac_q <= shadow_frac_d;
            active_int_q  <= active_int_d;
            active_frac_q <= active_frac_d;
            acc_q         <= acc_d;
            tune_code_q   <= tune_code_d;
            therm_en_q    <= therm_en_d;
            dither_bit_q  <= dither_bit_d;
            hi_cnt_q      <= hi_cnt_d;
            lo_cnt_q      <= lo_cnt_d;
            rail_hi_q     <= rail_hi_d;
            rail_lo_q     <= rail_lo_d;
        end
    end

    assign fcw.fcw_ready = fcw_ready_q;
    assign tune_code     = tune_code_q;
    assign therm_en      = therm_en_q;
    assign dither_bit    = dither_bit_q;
    assign rail_hi       = rail_hi_q;
    assign rail_lo       = rail_lo_q;

endmodule

// File: tb/tb_dco_tune_dsm.sv
// Directed scenarios plus randomized traffic for dco_tune_dsm, checked against
// an arithmetic model of the tuning rules.
module tb_dco_tune_dsm;

    localparam int INT_W  = 5;
    localparam int FRAC_W = 5;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                tick = 1'b0;
    logic                dsm_en = 1'b1;
    logic [INT_W-1:0]    tune_code;
    logic [31:0]         therm_en;
    logic                dither_bit;
    logic                rail_hi;
    logic                rail_lo;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_act_int, m_act_frac, m_sh_int, m_sh_frac, m_acc, m_code, m_dither, m_hi, m_lo;
    bit m_pending;

    dco_tune_dsm_if #(.INT_W(INT_W), .FRAC_W(FRAC_W)) bus ();

    dco_tune_dsm #(.INT_W(INT_W), .FRAC_W(FRAC_W), .MID_CODE(16), .RAIL_TICKS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .dsm_en     (dsm_en),
        .fcw        (bus),
        .tune_code  (tune_code),
        .therm_en   (therm_en),
        .dither_bit (dither_bit),
        .rail_hi    (rail_hi),
        .rail_lo    (rail_lo)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_act_int = 16; m_act_frac = 0; m_sh_int = 0; m_sh_frac = 0;
        m_acc = 0; m_code = 16; m_dither = 0; m_hi = 0; m_lo = 0; m_pending = 0;
    endtask

    task automatic model_update(input bit t, input bit en, input bit v, input int iw, input int fw);
        bit was_idle;
        int s, c;
        was_idle = !m_pending;
        if (t) begin
            if (m_pending) begin
                m_act_int = m_sh_int; m_act_frac = m_sh_frac; m_pending = 0;
            end
            c = 0;
            if (en) begin
                s = m_acc + m_act_frac;
                c = s / 32;
                m_acc = s % 32;
            end
            m_code = (m_act_int + c > 31) ? 31 : m_act_int + c;
            m_dither = c;
            if (m_code == 31) begin
                m_hi = (m_hi < 8) ? m_hi + 1 : 8; m_lo = 0;
            end else if (m_code == 0) begin
                m_lo = (m_lo < 8) ? m_lo + 1 : 8; m_hi = 0;
            end else begin
                m_hi = 0; m_lo = 0;
            end
        end
        if (v && was_idle) begin
            m_sh_int = iw; m_sh_frac = fw; m_pending = 1;
        end
    endtask

    // One clock: drive inputs, let the edge happen, sample 1 ns later.
    task automatic step(input bit t, input bit en, input bit v, input int iw, input int fw);
        tick = t;
        dsm_en = en;
        bus.fcw_valid = v;
        bus.int_word = INT_W'(iw);
        bus.frac_word = FRAC_W'(fw);
        @(posedge clk);
        #1;
        model_update(t, en, v, iw, fw);
        tick = 1'b0;
        bus.fcw_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.fcw_valid = 1'b0;
        bus.int_word = '0;
        bus.frac_word = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        checks++; if (tune_code !== 5'd16) begin errors++; $display("[TB] FAIL reset_code: got %0d expected 16", tune_code); end
        checks++; if (therm_en !== 32'h0000FFFF) begin errors++; $display("[TB] FAIL reset_therm: got %h expected 0000ffff", therm_en); end
        checks++; if (bus.fcw_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.fcw_ready); end
        checks++; if ({rail_hi, rail_lo, dither_bit} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {rail_hi, rail_lo, dither_bit}); end
    endtask

    task automatic test_integer_load();
        step(0, 1, 1, 10, 0);
        checks++; if (bus.fcw_ready !== 1'b0) begin errors++; $display("[TB] FAIL load_ready_low: got %b expected 0", bus.fcw_ready); end
        checks++; if (tune_code !== 5'd16) begin errors++; $display("[TB] FAIL load_no_tick_hold: got %0d expected 16", tune_code); end
        step(1, 1, 0, 0, 0);
        checks++; if (tune_code !== 5'd10) begin errors++; $display("[TB] FAIL load_code: got %0d expected 10", tune_code); end
        checks++; if (therm_en !== 32'h000003FF) begin errors++; $display("[TB] FAIL load_therm: got %h expected 000003ff", therm_en); end
        checks++; if (bus.fcw_ready !== 1'b1) begin errors++; $display("[TB] FAIL load_ready_high: got %b expected 1", bus.fcw_ready); end
    endtask

    task automatic test_dither();
        int exp_code[4] = '{10, 10, 10, 11};
        int exp_dith[4] = '{0, 0, 0, 1};
        step(0, 1, 1, 10, 8);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 0);
            checks++; if (tune_code !== 5'(exp_code[i]) || dither_bit !== 1'(exp_dith[i])) begin
                errors++; $display("[TB] FAIL dither_on_%0d: got code %0d bit %b expected code %0d bit %0d", i, tune_code, dither_bit, exp_code[i], exp_dith[i]);
            end
        end
        step(0, 0, 1, 10, 8);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0);
            checks++; if (tune_code !== 5'd10 || dither_bit !== 1'b0) begin
                errors++; $display("[TB] FAIL dither_off_%0d: got code %0d bit %b expected code 10 bit 0", i, tune_code, dither_bit);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 0);
            checks++; if (tune_code !== 5'(exp_code[i]) || dither_bit !== 1'(exp_dith[i])) begin
                errors++; $display("[TB] FAIL dither_hold_%0d: got code %0d bit %b expected code %0d bit %0d", i, tune_code, dither_bit, exp_code[i], exp_dith[i]);
            end
        end
        step(0, 1, 0, 0, 0);
        checks++; if (tune_code !== 5'd11 || dither_bit !== 1'b1) begin
            errors++; $display("[TB] FAIL dither_between_ticks: got code %0d bit %b expected code 11 bit 1", tune_code, dither_bit);
        end
    endtask

    task automatic test_saturation();
        step(0, 1, 1, 31, 31);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 0, 0);
            checks++; if (tune_code !== 5'd31 || therm_en !== 32'h7FFFFFFF) begin
                errors++; $display("[TB] FAIL sat_code_%0d: got %0d/%h expected 31/7fffffff", i, tune_code, therm_en);
            end
            checks++; if (rail_hi !== (i == 7) || rail_lo !== 1'b0) begin
                errors++; $display("[TB] FAIL sat_rail_%0d: got hi %b lo %b expected hi %0d lo 0", i, rail_hi, rail_lo, (i == 7));
            end
        end
        step(0, 1, 1, 20, 0);
        step(1, 1, 0, 0, 0);
        checks++; if (tune_code !== 5'd20 || therm_en !== 32'h000FFFFF) begin
            errors++; $display("[TB] FAIL sat_release_code: got %0d/%h expected 20/000fffff", tune_code, therm_en);
        end
        checks++; if (rail_hi !== 1'b0) begin errors++; $display("[TB] FAIL sat_release_rail: got %b expected 0", rail_hi); end
    endtask

    task automatic test_back_to_back();
        step(1, 1, 1, 5, 0);
        checks++; if (tune_code !== 5'd20) begin errors++; $display("[TB] FAIL b2b_old_code: got %0d expected 20", tune_code); end
        checks++; if (bus.fcw_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready: got %b expected 0", bus.fcw_ready); end
        step(1, 1, 0, 0, 0);
        checks++; if (tune_code !== 5'd5 || therm_en !== 32'h0000001F) begin
            errors++; $display("[TB] FAIL b2b_new_code: got %0d/%h expected 5/0000001f", tune_code, therm_en);
        end
        checks++; if (bus.fcw_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_back: got %b expected 1", bus.fcw_ready); end
    endtask

    task automatic test_reset_pending();
        step(0, 1, 1, 3, 0);
        checks++; if (bus.fcw_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstp_ready_low: got %b expected 0", bus.fcw_ready); end
        #2 reset = 1'b1;
        #1;
        checks++; if (tune_code !== 5'd16 || therm_en !== 32'h0000FFFF || bus.fcw_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL rstp_async: got code %0d therm %h ready %b expected 16 0000ffff 1", tune_code, therm_en, bus.fcw_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step(1, 1, 0, 0, 0);
        checks++; if (tune_code !== 5'd16 || therm_en !== 32'h0000FFFF) begin
            errors++; $display("[TB] FAIL rstp_after_tick: got %0d/%h expected 16/0000ffff", tune_code, therm_en);
        end
    endtask

    task automatic test_random();
        int base_int, base_frac, iw, fw;
        bit t, en, v;
        logic [31:0] exp_therm;
        for (int p = 0; p < 24; p++) begin
            case ($urandom_range(0, 3))
                0: base_int = 31;
                1: base_int = 0;
                default: base_int = int'($urandom_range(0, 31));
            endcase
            base_frac = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 31));
            for (int c = 0; c < 30; c++) begin
                t  = ($urandom_range(0, 1) == 1);
                en = ($urandom_range(0, 3) != 0);
                v  = ($urandom_range(0, 2) == 0);
                iw = base_int;
                fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : base_frac;
                step(t, en, v, iw, fw);
                exp_therm = 32'((64'd1 << m_code) - 64'd1);
                checks++;
                if (tune_code !== 5'(m_code) || therm_en !== exp_therm || dither_bit !== 1'(m_dither) ||
                    rail_hi !== (m_hi == 8) || rail_lo !== (m_lo == 8) || bus.fcw_ready !== !m_pending) begin
                    errors++;
                    $display("[TB] FAIL random_p%0d_c%0d: got code %0d therm %h dith %b hi %b lo %b rdy %b expected code %0d therm %h dith %0d hi %0d lo %0d rdy %0d",
                             p, c, tune_code, therm_en, dither_bit, rail_hi, rail_lo, bus.fcw_ready,
                             m_code, exp_therm, m_dither, (m_hi == 8), (m_lo == 8), !m_pending);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_integer_load();
        test_dither();
        test_saturation();
        test_back_to_back();
        test_reset_pending();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dco_tune_dsm.md
Name: dco_tune_dsm

Overview:
- Consumer end of the loop-filter frequency-word interface.
- Accepts integer/fractional tuning words from the PID loop filter through a valid/ready handshake and holds them in a shadow register.
- Transfers the words to an active register on DCO-rate ticks.
- Dithers the fractional part with a first-order sigma-delta accumulator and drives a thermometer-coded DCO capacitor-bank enable plus rail-detect status.

Parameters:
- INT_W, 5, integer tuning word width; capacitor bank has 2**INT_W unit cells.
- FRAC_W, 5, fractional tuning word / accumulator width.
- MID_CODE, 16, integer code loaded at reset (bank mid-scale).
- RAIL_TICKS, 8, consecutive saturated ticks before a rail flag asserts.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  DCO-rate update strobe, one clk wide; all code updates occur only on tick.
- dsm_en  in  1  1 = fractional dithering active; 0 = carry forced 0 and accumulator holds.
- fcw_valid  in  1  loop filter presents a new word pair.
- fcw_ready  out  1  block can accept a word pair.
- int_word  in  INT_W  integer tuning word, unsigned.
- frac_word  in  FRAC_W  fractional tuning word, unsigned, LSB = 2^-FRAC_W.
- tune_code  out  INT_W  effective bank code after dither and saturation.
- therm_en  out  2**INT_W  thermometer enables; bit i = 1 iff i < tune_code.
- dither_bit  out  1  sigma-delta carry applied on the last tick.
- rail_hi  out  1  tune_code held at max for RAIL_TICKS ticks.
- rail_lo  out  1  tune_code held at 0 for RAIL_TICKS ticks.

Behaviour:
- Reset (async): active_int=MID_CODE, active_frac=0, shadow cleared, acc=0, tune_code=MID_CODE, therm_en=MID_CODE ones (32'h0000FFFF at defaults), dither_bit=0, fcw_ready=1, rail_hi=rail_lo=0, rail counters=0, state=IDLE.
- States:
  - IDLE: no word pending, fcw_ready=1.
  - PENDING: shadow holds an unapplied word, fcw_ready=0.
- Accept: fcw_valid & fcw_ready in cycle N.
  - Shadow is loaded at edge N.
  - State becomes PENDING; fcw_ready is 0 from cycle N+1.
- Transfer: on a tick while PENDING, active registers load shadow and state returns to IDLE.
  - That same tick's computation uses the new active values.
  - fcw_ready returns to 1 the cycle after the tick.
- Accept and tick in the same cycle from IDLE: the word goes to shadow only.
  - That tick computes with the old active words.
  - The word applies on the next tick.
- On each tick, with dsm_en=1:
  - {carry, acc_next} = acc + active_frac, computed at FRAC_W+1 bits; acc <= acc_next.
- On each tick, with dsm_en=0: carry=0 and acc holds.
- The accumulator is never cleared on a word change; only reset clears it, preserving noise shaping.
- Code on each tick:
  - sum = active_int + carry, computed at INT_W+1 bits.
  - tune_code <= min(sum, 2**INT_W-1).
  - therm_en is registered from the same saturated value.
  - dither_bit <= carry.
- Latency: outputs change at the clk edge of the tick cycle and are visible the cycle after the tick; no change between ticks.
- Rail counters: updated on ticks only, saturating at RAIL_TICKS.
  - A tick producing code 2**INT_W-1 increments hi_cnt and clears lo_cnt.
  - A tick producing code 0 increments lo_cnt and clears hi_cnt.
  - Any other code clears both counters.
  - rail_hi = (hi_cnt == RAIL_TICKS); rail_lo = (lo_cnt == RAIL_TICKS); both registered.
- fcw_valid while fcw_ready=0: ignored; the source must hold the word.
- Reset mid-PENDING: shadow is discarded and all outputs return to reset values.

Test Plan:
- Reset, no ticks -> tune_code=16, therm_en=32'h0000FFFF, fcw_ready=1, rail_hi=rail_lo=0, dither_bit=0.
- Accept int=10, frac=0, then tick -> fcw_ready=0 after accept; after tick tune_code=10, therm_en=32'h000003FF, fcw_ready=1 the next cycle.
- Accept int=10, frac=8, dsm_en=1, 4 ticks -> acc 8,16,24,0; dither_bit 0,0,0,1; tune_code 10,10,10,11. Repeat with dsm_en=0 -> tune_code stays 10 and acc holds.
- Accept int=31, frac=31, 8 ticks -> tune_code stays 31 with carry (saturated) and rail_hi=1 after the 8th tick. Accept int=20, tick -> tune_code=20, rail_hi=0.
- Assert fcw_valid with int=5 in the same cycle as a tick from IDLE -> that tick yields the old code. Next tick -> tune_code=5.
- Accept int=3, assert reset before the next tick -> tune_code=16, fcw_ready=1. The tick after reset release leaves tune_code=16.
